// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request stream, in-order response queue, redirect flush.
// Optional build macro FETCH_MISALIGN_CHECK_EN turns a misaligned redirect into a fault entry.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            out_fault
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = CW + 1;

    typedef enum logic {FETCH = 1'b0, HALT = 1'b1} state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outst;
    logic [CW-1:0]   r_stale;
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [ILEN-1:0] r_q_inst  [DEPTH];
    logic [XLEN-1:0] r_q_pc    [DEPTH];
    logic            r_q_fault [DEPTH];

    logic            w_credit_ok;
    logic            w_hs;
    logic            w_resp_live;
    logic            w_enq;
    logic            w_deq;
    logic [CW-1:0]   w_outst_nxt;
    logic [XLEN-1:0] w_redir_pc;
    logic            w_misalign;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_redir_pc = redirect_pc;
    assign w_misalign = |redirect_pc[1:0];
`else
    assign w_redir_pc = redirect_pc & ~XLEN'(3);
    assign w_misalign = 1'b0;
`endif

    // Queued plus in-flight entries never exceed DEPTH, so a response always finds a free slot.
    assign w_credit_ok    = ({1'b0, r_count} + {1'b0, r_outst}) < SW'(DEPTH);
    assign imem_req_valid = !rst && (r_state == FETCH) && w_credit_ok;
    assign imem_req_addr  = r_pc;
    assign w_hs           = imem_req_valid && imem_req_ready;

    assign w_resp_live = imem_resp_valid && (r_stale == '0);
    assign w_enq       = !redirect_valid && w_resp_live && (r_state == FETCH);
    assign w_deq       = !redirect_valid && out_valid && out_ready;
    assign w_outst_nxt = r_outst + CW'(w_hs) - CW'(imem_resp_valid);

    assign out_valid = (r_count != '0);
    assign out_inst  = r_q_inst[r_rptr];
    assign out_pc    = r_q_pc[r_rptr];
    assign out_fault = r_q_fault[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= FETCH;
            r_pc      <= RESET_PC;
            r_resp_pc <= RESET_PC;
            r_count   <= '0;
            r_outst   <= '0;
            r_stale   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            if (redirect_valid) begin
                // Everything still in flight after this edge belongs to the old stream.
                r_pc      <= w_redir_pc;
                r_resp_pc <= w_redir_pc;
                r_stale   <= w_outst_nxt;
                r_rptr    <= '0;
                if (w_misalign) begin
                    r_state <= HALT;
                    r_count <= CW'(1);
                    r_wptr  <= AW'(1);
                end else begin
                    r_state <= FETCH;
                    r_count <= '0;
                    r_wptr  <= '0;
                end
            end else begin
                if (w_hs)
                    r_pc <= r_pc + XLEN'(4);
                if (imem_resp_valid) begin
                    if (r_stale != '0)
                        r_stale <= r_stale - CW'(1);
                    else
                        r_resp_pc <= r_resp_pc + XLEN'(4);
                end
                if (w_enq) begin
                    r_wptr <= r_wptr + AW'(1);
                    if (imem_resp_err)
                        r_state <= HALT;
                end
                if (w_deq)
                    r_rptr <= r_rptr + AW'(1);
                r_count <= r_count + CW'(w_enq) - CW'(w_deq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (redirect_valid && w_misalign) begin
            r_q_inst[0]  <= '0;
            r_q_pc[0]    <= w_redir_pc;
            r_q_fault[0] <= 1'b1;
        end else if (w_enq) begin
            r_q_inst[r_wptr]  <= imem_resp_data;
            r_q_pc[r_wptr]    <= r_resp_pc;
            r_q_fault[r_wptr] <= imem_resp_err;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: 1-cycle memory model with optional hold and error injection.
module tb_fetch_unit;
    localparam logic [31:0] MAGIC = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;

    fetch_unit #(.XLEN(32), .ILEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .out_fault       (out_fault)
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_hs   = 0;
    logic        last_hs;
    logic [31:0] last_addr;
    logic [31:0] mem_q[$];
    logic        mem_hold = 1'b0;
    logic        err_en   = 1'b0;
    logic [31:0] err_addr = 32'h0;
    logic [31:0] exp_pop;
    logic [31:0] exp_hs;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One clock: note the handshake, cross the edge, then present the next memory response.
    task automatic tick();
        logic        hs;
        logic [31:0] a;
        logic [31:0] ra;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_req_addr;
        @(posedge clk);
        #1;
        last_hs = hs;
        if (hs) begin
            mem_q.push_back(a);
            n_hs++;
            last_addr = a;
        end
        if (!mem_hold && mem_q.size() > 0) begin
            ra = mem_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = ra ^ MAGIC;
            imem_resp_err   = err_en && (ra == err_addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
            imem_resp_err   = 1'b0;
        end
    endtask

    task automatic redirect(input logic [31:0] pc);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        imem_resp_err = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;
        imem_req_ready = 1'b1;
        repeat (2) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 0);
        rst = 1'b0;
        #1;
        chk("first_req_valid", imem_req_valid, 1);
        chk("first_req_addr", imem_req_addr, 0);

        // Backpressure from empty: four requests fill the queue, then one pop buys one more.
        n_hs = 0;
        repeat (6) tick();
        chk("bp_hs_count", n_hs, 4);
        chk("bp_last_addr", last_addr, 32'hc);
        chk("bp_req_valid", imem_req_valid, 0);
        chk("bp_head_pc", out_pc, 0);
        chk("bp_head_inst", out_inst, MAGIC);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_pop_head", out_pc, 32'h4);
        chk("bp_req_after_pop", imem_req_valid, 1);
        repeat (3) tick();
        chk("bp_one_more", n_hs, 5);
        chk("bp_one_more_addr", last_addr, 32'h10);
        chk("bp_req_stop", imem_req_valid, 0);

        // Streaming: one pop per cycle with consecutive PCs and addresses.
        out_ready = 1'b1;
        exp_pop = 32'h4;
        exp_hs = 32'h14;
        n_hs = 0;
        for (int i = 0; i < 12; i++) begin
            chk("st_valid", out_valid, 1);
            chk("st_pc", out_pc, exp_pop);
            chk("st_inst", out_inst, exp_pop ^ MAGIC);
            exp_pop = exp_pop + 32'h4;
            tick();
            if (last_hs) begin
                chk("st_addr", last_addr, exp_hs);
                exp_hs = exp_hs + 32'h4;
            end
        end
        chk("st_hs_count", n_hs, 11);

        // Redirect with two requests in flight.
        mem_hold = 1'b1;
        repeat (2) tick();
        redirect(32'h100);
        chk("rd_out_valid", out_valid, 0);
        chk("rd_req_addr", imem_req_addr, 32'h100);
        chk("rd_req_valid", imem_req_valid, 1);
        mem_hold = 1'b0;
        imem_req_ready = 1'b1;
        tick();
        chk("rd_first_addr", last_addr, 32'h100);
        tick();
        chk("rd_drop1", out_valid, 0);
        tick();
        chk("rd_drop2", out_valid, 0);
        tick();
        chk("rd_new_valid", out_valid, 1);
        chk("rd_new_pc", out_pc, 32'h100);
        chk("rd_new_inst", out_inst, 32'h100 ^ MAGIC);

        // Access fault at 0x8 halts fetching until the next redirect.
        out_ready = 1'b0;
        err_en = 1'b1;
        err_addr = 32'h8;
        redirect(32'h0);
        imem_req_ready = 1'b1;
        n_hs = 0;
        repeat (6) tick();
        chk("flt_hs_count", n_hs, 4);
        chk("flt_req_valid", imem_req_valid, 0);
        chk("flt_head_pc", out_pc, 0);
        chk("flt_head_fault", out_fault, 0);
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        tick();
        chk("flt_pc", out_pc, 32'h8);
        chk("flt_fault", out_fault, 1);
        chk("flt_valid", out_valid, 1);
        chk("flt_no_req", n_hs, 4);
        chk("flt_halt_req", imem_req_valid, 0);
        err_en = 1'b0;
        redirect(32'h40);
        chk("flt_rd_out_valid", out_valid, 0);
        chk("flt_rd_req_valid", imem_req_valid, 1);
        chk("flt_rd_addr", imem_req_addr, 32'h40);
        imem_req_ready = 1'b1;
        tick();
        chk("flt_resume_addr", last_addr, 32'h40);

        // Misaligned redirect target.
        redirect(32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("mis_valid", out_valid, 1);
        chk("mis_pc", out_pc, 32'h102);
        chk("mis_fault", out_fault, 1);
        chk("mis_inst", out_inst, 0);
        chk("mis_req_valid", imem_req_valid, 0);
        imem_req_ready = 1'b1;
        n_hs = 0;
        tick();
        chk("mis_no_req", n_hs, 0);
        chk("mis_pc_hold", out_pc, 32'h102);
`else
        chk("mis_valid", out_valid, 0);
        chk("mis_req_valid", imem_req_valid, 1);
        chk("mis_req_addr", imem_req_addr, 32'h100);
        imem_req_ready = 1'b1;
        n_hs = 0;
        tick();
        chk("mis_hs", n_hs, 1);
        chk("mis_addr", last_addr, 32'h100);
`endif

        // Fill the queue, then reset asynchronously in the middle of a cycle.
        out_ready = 1'b0;
        redirect(32'h200);
        imem_req_ready = 1'b1;
        repeat (8) tick();
        chk("full_valid", out_valid, 1);
        chk("full_head", out_pc, 32'h200);
        chk("full_req_valid", imem_req_valid, 0);
        #2;
        rst = 1'b1;
        mem_q.delete();
        imem_resp_valid = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_req_valid", imem_req_valid, 0);
        chk("arst_req_addr", imem_req_addr, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rel_req_valid", imem_req_valid, 1);
        chk("rel_out_valid", out_valid, 0);
        tick();
        chk("rel_first_addr", last_addr, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- XLEN, 32, address/data width.
- ILEN, 32, instruction width.
- DEPTH, 4, instruction queue entries; power of two, >= 2.
- RESET_PC, 0, fetch address after reset.

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address.
- imem_resp_valid  in  1  in-order response valid; always accepted.
- imem_resp_data  in  ILEN  fetched instruction.
- imem_resp_err  in  1  access fault for the response.
- redirect_valid  in  1  flush and refetch request.
- redirect_pc  in  XLEN  new fetch address.
- out_valid  out  1  queue head valid.
- out_ready  in  1  consumer pops head.
- out_inst  out  ILEN  head instruction.
- out_pc  out  XLEN  head PC.
- out_fault  out  1  head is a fault entry.

Function
REQ-003 A request handshake SHALL occur when imem_req_valid and imem_req_ready are both high; each handshake SHALL advance pc by 4, wrapping modulo 2^XLEN.
- imem_req_addr SHALL equal pc.

REQ-004 imem_req_valid SHALL be high only in state FETCH and only when (queue count + outstanding) < DEPTH.
- It SHALL NOT depend combinationally on redirect_valid.

REQ-005 Outstanding requests SHALL be tracked as follows:
- The outstanding counter SHALL increment on each handshake and decrement on each response.
- Its range SHALL be 0..DEPTH.

REQ-006 Queue entries SHALL be written and read as follows:
- A non-stale response SHALL enqueue {data, pc of its request, err}.
- It SHALL be visible at out_* the next cycle (1-cycle latency).

REQ-007 out_valid SHALL equal (queue not empty).
- The head SHALL be popped when out_valid && out_ready.
- Enqueue and dequeue in the same cycle SHALL both take effect.

REQ-008 The state machine SHALL have states FETCH and HALT.
- FETCH -> HALT when an enqueued response has err=1.
- HALT issues no requests and discards non-stale responses.
- HALT -> FETCH only on redirect.

REQ-009 On redirect_valid, at the next edge, the block SHALL:
- empty the queue;
- set pc = redirect_pc;
- set state = FETCH;
- set stale = outstanding + (handshake this cycle ? 1 : 0) - (response this cycle ? 1 : 0).

REQ-010 While stale > 0, each response SHALL decrement stale and SHALL be dropped without enqueuing.

REQ-011 A redirect SHALL take priority over a same-cycle pop, enqueue, or state transition; none of those SHALL take effect.

REQ-012 A response arriving when the queue is full SHALL be impossible by construction; credit accounting per REQ-004 SHALL guarantee this.

Reset
REQ-013 While rst is high, asynchronously:
- pc = RESET_PC;
- queue empty;
- outstanding = 0;
- stale = 0;
- state = FETCH;
- out_valid = 0;
- imem_req_valid = 0.

REQ-014 The first request SHALL be issued on the first rising edge after rst deasserts.

REQ-015 Responses arriving after reset for requests issued before reset SHALL NOT occur; the memory is reset together with this block.

Configuration
REQ-016 With FETCH_MISALIGN_CHECK_EN defined, a redirect with redirect_pc[1:0] != 0 SHALL:
- empty the queue;
- enqueue one entry {inst=0, pc=redirect_pc, fault=1};
- enter HALT with no request issued.

REQ-017 With FETCH_MISALIGN_CHECK_EN undefined, redirect_pc[1:0] SHALL be forced to 0, and no misalignment fault SHALL exist.

Verification
REQ-018 Streaming: rst released, req_ready=1, 1-cycle memory, out_ready=1 -> addresses 0x0, 0x4, 0x8, ... in order, out_pc matching, no gaps after fill.

REQ-019 Backpressure: out_ready=0, DEPTH=4 -> exactly 4 handshakes, then imem_req_valid=0; one pop -> exactly one new request.

REQ-020 Redirect with 2 outstanding, redirect_pc=0x100 -> next 2 responses dropped, queue empty, next request address 0x100.

REQ-021 Fault: response at pc 0x8 with err=1 -> out_fault=1, out_pc=0x8, no further requests; redirect to 0x40 -> fetch resumes at 0x40.

REQ-022 Misalign: redirect_pc=0x102 -> with macro: single entry out_pc=0x102, out_fault=1, state HALT; without macro: fetch from 0x100.

REQ-023 Reset mid-operation: rst asserted with queue full -> out_valid=0 and imem_req_valid=0 immediately, without waiting for a clock edge.
